// File: rtl/clause_bin_loader_if.sv
// Bundle of the loader's command, bin-RAM, learnt-clause and clause-array signals.
// master = the loader itself; slave = the environment (RAM, array, solver control).
interface clause_bin_loader_if #(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_ADDR  = 8
) ();
  logic                     start_load_i;
  logic [WIDTH_ADDR-1:0]    base_addr_i;
  logic [WIDTH_C_LEN-1:0]   nclauses_i;
  logic                     mem_rd_o;
  logic [WIDTH_ADDR-1:0]    mem_addr_o;
  logic [NUM_VARS*2-1:0]    mem_data_i;
  logic                     learntc_valid_i;
  logic [NUM_VARS*2-1:0]    learntc_i;
  logic                     learntc_ready_o;
  logic [NUM_CLAUSES-1:0]   wr_o;
  logic [NUM_VARS*2-1:0]    clause_o;
  logic [WIDTH_C_LEN-1:0]   clause_len_o;
  logic                     add_learntc_en_o;
  logic                     apply_impl_o;
  logic                     done_o;
  logic                     busy_o;
  logic                     err_o;

  modport master (
    input  start_load_i, base_addr_i, nclauses_i, mem_data_i, learntc_valid_i, learntc_i,
    output mem_rd_o, mem_addr_o, learntc_ready_o, wr_o, clause_o, clause_len_o,
           add_learntc_en_o, apply_impl_o, done_o, busy_o, err_o
  );

  modport slave (
    output start_load_i, base_addr_i, nclauses_i, mem_data_i, learntc_valid_i, learntc_i,
    input  mem_rd_o, mem_addr_o, learntc_ready_o, wr_o, clause_o, clause_len_o,
           add_learntc_en_o, apply_impl_o, done_o, busy_o, err_o
  );
endinterface

// File: rtl/clause_bin_loader.sv
// Streams a clause bin from bin RAM into clause-array rows, or forwards one learnt clause.
// Optional literal checking (sticky err_o) is built when LOADER_LIT_CHECK_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for start_load_i or a learnt clause
// S_READ   | issuing one bin-RAM read per cycle
// S_DRAIN  | reads done, last two registered rows still being written
// S_LEARNT | learnt clause presented with add_learntc_en_o
// S_IMPL   | apply_impl_o pulse
// S_DONE   | done_o pulse, back to idle next cycle
module clause_bin_loader #(
  parameter int NUM_CLAUSES = 8,
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_ADDR  = 8
) (
  input logic                 clk,
  input logic                 rst,
  clause_bin_loader_if.master bus
);
  localparam int W_LIT = NUM_VARS * 2;
  localparam logic [WIDTH_C_LEN-1:0] LEN_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_LEARNT, S_IMPL, S_DONE
  } state_t;

  function automatic logic [WIDTH_C_LEN-1:0] clause_len(input logic [W_LIT-1:0] lits);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_VARS; i++)
      if (lits[2*i +: 2] != 2'b00) cnt = cnt + 1;
    if (cnt > int'(LEN_MAX)) return LEN_MAX;
    return WIDTH_C_LEN'(cnt);
  endfunction

  state_t                  state;
  logic [WIDTH_C_LEN-1:0]  rd_left;
  logic                    drain_left;
  logic                    rd_d1;
  logic [NUM_CLAUSES-1:0]  wr_oh;
  logic                    mem_rd_q;
  logic [WIDTH_ADDR-1:0]   mem_addr_q;
  logic [NUM_CLAUSES-1:0]  wr_q;
  logic [W_LIT-1:0]        clause_q;
  logic [WIDTH_C_LEN-1:0]  len_q;
  logic                    add_q;
  logic                    apply_q;
  logic                    done_q;
  logic                    busy_q;
  logic [WIDTH_C_LEN-1:0]  n_eff;
  logic                    accept_learnt;

  always_comb begin
    n_eff = bus.nclauses_i;
    if (32'(bus.nclauses_i) > NUM_CLAUSES) n_eff = WIDTH_C_LEN'(NUM_CLAUSES);
  end

  assign accept_learnt = (state == S_IDLE) && bus.learntc_valid_i && !bus.start_load_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rd_left    <= '0;
      drain_left <= 1'b0;
      rd_d1      <= 1'b0;
      wr_oh      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      wr_q       <= '0;
      clause_q   <= '0;
      len_q      <= '0;
      add_q      <= 1'b0;
      apply_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_d1   <= mem_rd_q;
      add_q   <= 1'b0;
      apply_q <= 1'b0;
      done_q  <= 1'b0;
      // RAM data arrives the cycle after the read strobe; register it straight into a row write
      if (rd_d1) begin
        wr_q     <= wr_oh;
        clause_q <= bus.mem_data_i;
        len_q    <= clause_len(bus.mem_data_i);
        wr_oh    <= wr_oh << 1;
      end else begin
        wr_q <= '0;
      end
      case (state)
        S_IDLE: begin
          if (bus.start_load_i) begin
            busy_q <= 1'b1;
            wr_oh  <= NUM_CLAUSES'(1);
            if (n_eff == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state      <= S_READ;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= bus.base_addr_i;
              rd_left    <= n_eff - 1'b1;
            end
          end else if (accept_learnt) begin
            state    <= S_LEARNT;
            busy_q   <= 1'b1;
            add_q    <= 1'b1;
            clause_q <= bus.learntc_i;
            len_q    <= clause_len(bus.learntc_i);
          end
        end
        S_READ: begin
          if (rd_left == '0) begin
            mem_rd_q   <= 1'b0;
            drain_left <= 1'b1;
            state      <= S_DRAIN;
          end else begin
            mem_addr_q <= mem_addr_q + 1'b1;
            rd_left    <= rd_left - 1'b1;
          end
        end
        S_DRAIN: begin
          if (!drain_left) begin
            state   <= S_IMPL;
            apply_q <= 1'b1;
          end else begin
            drain_left <= 1'b0;
          end
        end
        S_LEARNT: begin
          state   <= S_IMPL;
          apply_q <= 1'b1;
        end
        S_IMPL: begin
          state  <= S_DONE;
          done_q <= 1'b1;
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LOADER_LIT_CHECK_EN
  function automatic logic lit_bad(input logic [W_LIT-1:0] lits);
    logic bad;
    bad = (lits == '0);
    for (int i = 0; i < NUM_VARS; i++)
      if (lits[2*i +: 2] == 2'b11) bad = 1'b1;
    return bad;
  endfunction

  logic err_q;

  // Flag is raised on the same edge that registers the offending write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((rd_d1 && lit_bad(bus.mem_data_i)) ||
                 (accept_learnt && lit_bad(bus.learntc_i))) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.learntc_ready_o  = accept_learnt & rst;
  assign bus.mem_rd_o         = mem_rd_q;
  assign bus.mem_addr_o       = mem_addr_q;
  assign bus.wr_o             = wr_q;
  assign bus.clause_o         = clause_q;
  assign bus.clause_len_o     = len_q;
  assign bus.add_learntc_en_o = add_q;
  assign bus.apply_impl_o     = apply_q;
  assign bus.done_o           = done_q;
  assign bus.busy_o           = busy_q;
endmodule

// File: tb/tb_clause_bin_loader.sv
// Scoreboard bench for clause_bin_loader: stimulus pushes cycle-stamped expected events,
// a negedge monitor pops and compares every read, write, learnt write, apply and done.
module tb_clause_bin_loader;
  localparam logic [2:0] K_RD = 3'd1, K_WR = 3'd2, K_LRN = 3'd3, K_IMPL = 3'd4, K_DONE = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    int unsigned cyc;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  len;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc_cnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  logic        mon_en = 1'b0;
  ev_t         exp_q[$];
  logic [15:0] mem[256];
  logic [15:0] vdat[8];
  logic [3:0]  vlen[8];
  logic        exp_err;

  clause_bin_loader_if #(.NUM_CLAUSES(8), .NUM_VARS(8), .WIDTH_C_LEN(4), .WIDTH_ADDR(8)) bus ();

  clause_bin_loader #(.NUM_CLAUSES(8), .NUM_VARS(8), .WIDTH_C_LEN(4), .WIDTH_ADDR(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(posedge clk) if (bus.mem_rd_o) bus.mem_data_i <= mem[bus.mem_addr_o];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input int unsigned cyc, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] len);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.a = a; e.b = b; e.len = len;
    exp_q.push_back(e);
  endtask

  // Expected event train of a load of ne clauses (ne already clamped by hand)
  task automatic expect_load(input int unsigned c0, input logic [7:0] base, input int ne);
    logic [7:0] ad;
    if (ne == 0) push(K_DONE, c0 + 1, 16'h0, 16'h0, 4'h0);
    for (int c = 1; c <= ne + 4 && ne > 0; c++) begin
      ad = base + 8'(c - 1);
      if (c <= ne) push(K_RD, c0 + c, {8'h00, ad}, 16'h0, 4'h0);
      if (c >= 3 && c <= ne + 2) push(K_WR, c0 + c, 16'h1 << (c - 3), vdat[c-3], vlen[c-3]);
      if (c == ne + 3) push(K_IMPL, c0 + c, 16'h0, 16'h0, 4'h0);
      if (c == ne + 4) push(K_DONE, c0 + c, 16'h0, 16'h0, 4'h0);
    end
  endtask

  task automatic sb_check(input logic [2:0] kind, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] len);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected got kind=%0d cyc=%0d a=%h b=%h len=%0d required no event",
               kind, cyc_cnt, a, b, len);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc_cnt || e.a != a || e.b != b || e.len != len) begin
        n_fail++;
        $display("FAIL sb_event got kind=%0d cyc=%0d a=%h b=%h len=%0d required kind=%0d cyc=%0d a=%h b=%h len=%0d",
                 kind, cyc_cnt, a, b, len, e.kind, e.cyc, e.a, e.b, e.len);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (bus.mem_rd_o) sb_check(K_RD, {8'h00, bus.mem_addr_o}, 16'h0, 4'h0);
      if (bus.wr_o != '0) begin
        wr_cnt++;
        sb_check(K_WR, {8'h00, bus.wr_o}, bus.clause_o, bus.clause_len_o);
      end
      if (bus.add_learntc_en_o) sb_check(K_LRN, 16'h0, bus.clause_o, bus.clause_len_o);
      if (bus.apply_impl_o) sb_check(K_IMPL, 16'h0, 16'h0, 4'h0);
      if (bus.done_o) sb_check(K_DONE, 16'h0, 16'h0, 4'h0);
    end
  end

  task automatic chk_all_zero(input string name);
    chk(name, {bus.mem_rd_o, bus.mem_addr_o, bus.wr_o, bus.clause_o, bus.clause_len_o,
               bus.add_learntc_en_o, bus.apply_impl_o, bus.done_o, bus.busy_o, bus.err_o,
               bus.learntc_ready_o}, 32'h0);
  endtask

  task automatic settle(input int n, input string name);
    repeat (n) @(negedge clk);
    chk({name, "_busy"}, bus.busy_o, 1'b0);
    chk({name, "_qempty"}, exp_q.size(), 0);
  endtask

  initial begin
    int unsigned c0;
    int          wr_before;
    ev_t         e;
`ifdef LOADER_LIT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b0;
    bus.start_load_i = 1'b0; bus.base_addr_i = '0; bus.nclauses_i = '0;
    bus.learntc_valid_i = 1'b0; bus.learntc_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0001;
    mem[8'h10] = 16'h0001; mem[8'h11] = 16'h0005; mem[8'h12] = 16'h0155;
    mem[8'h20] = 16'h0001; mem[8'h21] = 16'h0002; mem[8'h22] = 16'h0009; mem[8'h23] = 16'h0015;
    mem[8'h24] = 16'h0055; mem[8'h25] = 16'h0155; mem[8'h26] = 16'h0555; mem[8'h27] = 16'h5555;
    mem[8'hFE] = 16'h0009; mem[8'hFF] = 16'hAAAA; mem[8'h00] = 16'h4000;
    mem[8'h30] = 16'h0015; mem[8'h40] = 16'h0001; mem[8'h41] = 16'h0002;
    mem[8'h60] = 16'h0003;

    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    rst = 1'b1;

    // Reset asserted in the middle of a load
    @(negedge clk);
    bus.start_load_i = 1'b1; bus.base_addr_i = 8'h20; bus.nclauses_i = 4'd8;
    @(negedge clk);
    bus.start_load_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("midload_busy", bus.busy_o, 1'b1);
    rst = 1'b0;
    #1 chk_all_zero("midload_rst");
    repeat (2) @(negedge clk);
    chk_all_zero("midload_rst_hold");
    rst = 1'b1;
    mon_en = 1'b1;
    settle(12, "after_rst");
    chk("after_rst_writes", wr_cnt, 0);

    // Basic load, base 0x10, three clauses
    vdat[0] = 16'h0001; vlen[0] = 4'd1;
    vdat[1] = 16'h0005; vlen[1] = 4'd2;
    vdat[2] = 16'h0155; vlen[2] = 4'd5;
    @(negedge clk);
    bus.start_load_i = 1'b1; bus.base_addr_i = 8'h10; bus.nclauses_i = 4'd3; c0 = cyc_cnt;
    expect_load(c0, 8'h10, 3);
    @(negedge clk);
    bus.start_load_i = 1'b0;
    chk("load3_busy_c1", bus.busy_o, 1'b1);
    settle(8, "load3");

    // Zero clauses: only a done pulse at cycle 1
    @(negedge clk);
    bus.start_load_i = 1'b1; bus.base_addr_i = 8'h10; bus.nclauses_i = 4'd0; c0 = cyc_cnt;
    expect_load(c0, 8'h10, 0);
    @(negedge clk);
    bus.start_load_i = 1'b0;
    chk("n0_busy_c1", bus.busy_o, 1'b1);
    settle(4, "n0");

    // Twelve requested, clamps to eight rows
    vdat[0] = 16'h0001; vlen[0] = 4'd1; vdat[1] = 16'h0002; vlen[1] = 4'd1;
    vdat[2] = 16'h0009; vlen[2] = 4'd2; vdat[3] = 16'h0015; vlen[3] = 4'd3;
    vdat[4] = 16'h0055; vlen[4] = 4'd4; vdat[5] = 16'h0155; vlen[5] = 4'd5;
    vdat[6] = 16'h0555; vlen[6] = 4'd6; vdat[7] = 16'h5555; vlen[7] = 4'd8;
    wr_before = wr_cnt;
    @(negedge clk);
    bus.start_load_i = 1'b1; bus.base_addr_i = 8'h20; bus.nclauses_i = 4'd12; c0 = cyc_cnt;
    expect_load(c0, 8'h20, 8);
    @(negedge clk);
    bus.start_load_i = 1'b0;
    settle(14, "n12");
    chk("n12_writes", wr_cnt - wr_before, 8);

    // Address wrap FE, FF, 00
    vdat[0] = 16'h0009; vlen[0] = 4'd2;
    vdat[1] = 16'hAAAA; vlen[1] = 4'd8;
    vdat[2] = 16'h4000; vlen[2] = 4'd1;
    @(negedge clk);
    bus.start_load_i = 1'b1; bus.base_addr_i = 8'hFE; bus.nclauses_i = 4'd3; c0 = cyc_cnt;
    expect_load(c0, 8'hFE, 3);
    @(negedge clk);
    bus.start_load_i = 1'b0;
    settle(8, "wrap");

    // Learnt clause forwarding
    @(negedge clk);
    bus.learntc_valid_i = 1'b1; bus.learntc_i = 16'h0009; c0 = cyc_cnt;
    push(K_LRN, c0 + 1, 16'h0, 16'h0009, 4'd2);
    push(K_IMPL, c0 + 2, 16'h0, 16'h0, 4'h0);
    push(K_DONE, c0 + 3, 16'h0, 16'h0, 4'h0);
    #1 chk("learnt_ready", bus.learntc_ready_o, 1'b1);
    @(negedge clk);
    chk("learnt_ready_busy", bus.learntc_ready_o, 1'b0);
    chk("learnt_wr_zero", bus.wr_o, 8'h00);
    bus.learntc_valid_i = 1'b0;
    settle(5, "learnt");

    // Start and learnt offered together: load wins
    vdat[0] = 16'h0015; vlen[0] = 4'd3;
    @(negedge clk);
    bus.start_load_i = 1'b1; bus.base_addr_i = 8'h30; bus.nclauses_i = 4'd1;
    bus.learntc_valid_i = 1'b1; bus.learntc_i = 16'h0005; c0 = cyc_cnt;
    expect_load(c0, 8'h30, 1);
    #1 chk("collide_ready", bus.learntc_ready_o, 1'b0);
    @(negedge clk);
    bus.start_load_i = 1'b0; bus.learntc_valid_i = 1'b0;
    settle(6, "collide");

    // Start while busy is ignored
    vdat[0] = 16'h0001; vlen[0] = 4'd1;
    vdat[1] = 16'h0002; vlen[1] = 4'd1;
    wr_before = wr_cnt;
    @(negedge clk);
    bus.start_load_i = 1'b1; bus.base_addr_i = 8'h40; bus.nclauses_i = 4'd2; c0 = cyc_cnt;
    expect_load(c0, 8'h40, 2);
    @(negedge clk);
    bus.start_load_i = 1'b0;
    @(negedge clk);
    bus.start_load_i = 1'b1; bus.base_addr_i = 8'h50; bus.nclauses_i = 4'd3;
    @(negedge clk);
    bus.start_load_i = 1'b0;
    settle(8, "busy_start");
    chk("busy_start_writes", wr_cnt - wr_before, 2);

    // Reserved literal pair
    chk("err_before", bus.err_o, 1'b0);
    vdat[0] = 16'h0003; vlen[0] = 4'd1;
    @(negedge clk);
    bus.start_load_i = 1'b1; bus.base_addr_i = 8'h60; bus.nclauses_i = 4'd1; c0 = cyc_cnt;
    expect_load(c0, 8'h60, 1);
    @(negedge clk);
    bus.start_load_i = 1'b0;
    settle(6, "lit11");
    chk("err_set", bus.err_o, exp_err);
    repeat (5) @(negedge clk);
    chk("err_sticky", bus.err_o, exp_err);
    rst = 1'b0;
    #1 chk("err_cleared", bus.err_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL sb_missing got no event required kind=%0d cyc=%0d a=%h", e.kind, e.cyc, e.a);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
